line_follow_pi_ctrl: RTL and testbench
======================================

// Module: line_follow_pi_ctrl
// PURPOSE
// Parametrised line-follower motion controller for NUM_PAIRS IR sensor pairs.
// For each pair it strobes the IR emitter, samples the right and left channels through
// the shared A2D, and accumulates a 2^k-weighted right-minus-left error.
// A PI loop with forward ramp then produces signed left/right motor drive.
// Adds a conversion timeout, a sticky fault flag and a per-cycle update strobe.
// PARAMETERS
// NUM_PAIRS   3        sensor pairs, legal 1..4; pair k weight = 2^k
// CH_MAP      24'o00732401  A2D channel per read slot i (3 bits each, i=2k right, 2k+1 left)
// SETTLE_CLKS 4096     emitter settle clocks before right-channel conversion
// GAP_CLKS    32       clocks between right-done and left start_conv
// CNV_TIMEOUT 1024     max clocks waiting for cnv_cmplt
// IR_DUTY     8'h8C    emitter PWM duty (high while free 8-bit counter < IR_DUTY)
// P_TERM      14'h3680 proportional gain, unsigned
// I_TERM      12'h500  integral gain, unsigned
// INT_DEC     4        integrate every INT_DEC-th control cycle (power of 2)
// FWD_MAX     12'h700  forward-speed ceiling; FWD_STEP 1 = ramp increment per cycle
// PORTS
// clk        in  1   system clock
// rst_n      in  1   async active-low reset
// go         in  1   run enable; low = abort and clear
// cnv_cmplt  in  1   A2D conversion done (1-cycle pulse)
// A2D_res    in  12  A2D result, unsigned, valid with cnv_cmplt
// start_conv out 1   1-cycle A2D start pulse
// chnnl      out 3   A2D channel select, stable from start_conv to cnv_cmplt
// IR_en      out NUM_PAIRS  emitter enables, one-hot gated by PWM
// LEDs       out 8   Error[11:4]
// lft, rht   out 11  motor drive = lft_reg[11:1], rht_reg[11:1] (signed)
// update     out 1   1-cycle pulse when lft/rht refreshed
// fault      out 1   sticky conversion-timeout flag, cleared only by go low or reset
// BEHAVIOUR
// Clock clk, reset rst_n asynchronous active-low: all regs 0, state IDLE, outputs 0.
// States: IDLE, SETTLE, WAIT_R, GAP, WAIT_L, ERR, INTG, COMP, OUT.
// IDLE: go=1 -> SETTLE, k=0, timer=0. go=0 in any state -> IDLE next clk; Accum, Error,
//   Intgrl, Fwd, lft_reg, rht_reg, fault cleared; start_conv/IR_en low; cnv_cmplt ignored.
// SETTLE: IR_en[k]=pwm; on timer==SETTLE_CLKS-1 pulse start_conv, chnnl=CH_MAP[2k] -> WAIT_R.
// WAIT_R: cnv_cmplt -> Accum += A2D_res<<k (16b signed), timer=0 -> GAP.
// GAP: IR_en[k] held; on timer==GAP_CLKS-1 start_conv, chnnl=CH_MAP[2k+1] -> WAIT_L.
// WAIT_L: cnv_cmplt -> Accum -= A2D_res<<k; k<NUM_PAIRS-1 ? k++,SETTLE : ERR.
// Timeout: CNV_TIMEOUT clks in WAIT_R/WAIT_L without cnv_cmplt -> fault=1, Accum=0,
//   k=0, -> SETTLE; lft/rht hold last value, no update pulse.
// ERR: Error = sat12(Accum) (clamp to 12'h7FF / 12'h800); Accum=0.
// INTG: on every INT_DEC-th cycle Intgrl = sat12(Intgrl + (Error>>>4));
//   Fwd = min(Fwd+FWD_STEP, FWD_MAX) every cycle.
// COMP: Pcomp = sat12((Error*P_TERM)>>>12); Icomp = sat12((Intgrl*I_TERM)>>>12).
// OUT: rht_reg = sat12(Fwd-Pcomp-Icomp); lft_reg = sat12(Fwd+Pcomp+Icomp); update=1;
//   -> SETTLE k=0 (go high). Control latency ERR->update = 3 clks.
// Saturation always signed 12-bit; intermediate sums carried at >=17 bits.
// cnv_cmplt in non-WAIT states ignored. chnnl holds last value outside conversions.
// TESTING
// Reset mid-WAIT_L: rst_n low -> all outputs 0, IDLE; go high -> IR_en[0] after 1 clk.
// Balanced: all A2D_res=12'h400 -> Error=0, LEDs=0, lft==rht==Fwd[11:1], update per cycle.
// Right-heavy pair2: R2=12'hFFF, others 0 -> Accum 16'h3FFC, Error sat 12'h7FF, rht<lft.
// Timeout: withhold cnv_cmplt 1024 clks in WAIT_R -> fault=1, outputs held, next cycle runs.
// Sequencing: check chnnl order 1,0,4,2,3,7 and start_conv 4096/32 clk spacing, 1 clk wide.
// Ramp/abort: 1800 cycles go high -> Fwd stops at 12'h700; go low -> all cleared next clk.

Source files
------------

// File: rtl/line_follow_pi_ctrl.sv
// Line-follower controller: sequences IR emitter/A2D reads per sensor pair, builds a
// weighted right-minus-left error and drives signed left/right motor commands via a PI loop.
module line_follow_pi_ctrl #(
    parameter int unsigned NUM_PAIRS   = 3,
    parameter logic [23:0] CH_MAP      = 24'o00732401,
    parameter int unsigned SETTLE_CLKS = 4096,
    parameter int unsigned GAP_CLKS    = 32,
    parameter int unsigned CNV_TIMEOUT = 1024,
    parameter logic [7:0]  IR_DUTY     = 8'h8C,
    parameter logic [13:0] P_TERM      = 14'h3680,
    parameter logic [11:0] I_TERM      = 12'h500,
    parameter int unsigned INT_DEC     = 4,
    parameter logic [11:0] FWD_MAX     = 12'h700,
    parameter logic [11:0] FWD_STEP    = 12'h001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 cnv_cmplt,
    input  logic [11:0]          A2D_res,
    output logic                 start_conv,
    output logic [2:0]           chnnl,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [7:0]           LEDs,
    output logic [10:0]          lft,
    output logic [10:0]          rht,
    output logic                 update,
    output logic                 fault
);

    localparam int unsigned IW = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
    localparam logic [1:0]    LAST_K      = 2'(NUM_PAIRS - 1);
    localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CLKS - 1);
    localparam logic [15:0]   GAP_LAST    = 16'(GAP_CLKS - 1);
    localparam logic [15:0]   CNV_LAST    = 16'(CNV_TIMEOUT - 1);
    localparam logic [IW-1:0] INT_LAST    = IW'(INT_DEC - 1);

    typedef enum logic [3:0] {
        IDLE, SETTLE, WAIT_R, GAP, WAIT_L, ERR, INTG, COMP, OUT
    } state_t;

    state_t              state;
    logic [1:0]          k;
    logic [15:0]         timer;
    logic signed [16:0]  accum;
    logic signed [11:0]  error;
    logic signed [11:0]  intgrl;
    logic signed [11:0]  pcomp;
    logic signed [11:0]  icomp;
    logic signed [11:0]  lft_reg;
    logic signed [11:0]  rht_reg;
    logic [11:0]         fwd;
    logic [IW-1:0]       int_cnt;
    logic [7:0]          pwm_cnt;
    logic                pwm;

    logic [2:0]          ch_r, ch_l;
    logic signed [31:0]  a2d_sh, acc_ext, intg_sum, p_prod, i_prod;
    logic signed [31:0]  drive, fwd_ext, rht_sum, lft_sum;
    logic [12:0]         fwd_sum;
    logic [11:0]         fwd_nxt;

    function automatic logic signed [11:0] sat12(input logic signed [31:0] v);
        if (v > 32'sd2047)
            return 12'sh7FF;
        else if (v < -32'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

    always_comb begin
        ch_r = '0;
        ch_l = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (k == 2'(i)) begin
                ch_r = CH_MAP[6*i +: 3];
                ch_l = CH_MAP[6*i+3 +: 3];
            end
        end
        a2d_sh   = $signed(32'(A2D_res) << k);
        acc_ext  = 32'(accum);
        intg_sum = 32'(intgrl) + (32'(error) >>> 4);
        p_prod   = (32'(error) * $signed(32'(P_TERM))) >>> 12;
        i_prod   = (32'(intgrl) * $signed(32'(I_TERM))) >>> 12;
        drive    = 32'(pcomp) + 32'(icomp);
        fwd_ext  = $signed(32'(fwd));
        rht_sum  = fwd_ext - drive;
        lft_sum  = fwd_ext + drive;
        fwd_sum  = {1'b0, fwd} + {1'b0, FWD_STEP};
        fwd_nxt  = (fwd_sum > {1'b0, FWD_MAX}) ? FWD_MAX : fwd_sum[11:0];
    end

    // Emitter for the active pair follows the PWM only while that pair is being read.
    always_comb begin
        IR_en = '0;
        if (state inside {SETTLE, WAIT_R, GAP, WAIT_L})
            IR_en = (NUM_PAIRS'(1) << k) & {NUM_PAIRS{pwm}};
    end

    assign LEDs = error[11:4];
    assign lft  = lft_reg[11:1];
    assign rht  = rht_reg[11:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            timer      <= '0;
            accum      <= '0;
            error      <= '0;
            intgrl     <= '0;
            pcomp      <= '0;
            icomp      <= '0;
            lft_reg    <= '0;
            rht_reg    <= '0;
            fwd        <= '0;
            int_cnt    <= '0;
            pwm_cnt    <= '0;
            pwm        <= 1'b0;
            start_conv <= 1'b0;
            chnnl      <= '0;
            update     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            start_conv <= 1'b0;
            update     <= 1'b0;
            pwm_cnt    <= pwm_cnt + 8'd1;
            pwm        <= (pwm_cnt < IR_DUTY);
            if (!go) begin
                state   <= IDLE;
                k       <= '0;
                timer   <= '0;
                accum   <= '0;
                error   <= '0;
                intgrl  <= '0;
                pcomp   <= '0;
                icomp   <= '0;
                lft_reg <= '0;
                rht_reg <= '0;
                fwd     <= '0;
                int_cnt <= '0;
                fault   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        k     <= '0;
                        timer <= '0;
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        if (timer == SETTLE_LAST) begin
                            start_conv <= 1'b1;
                            chnnl      <= ch_r;
                            timer      <= '0;
                            state      <= WAIT_R;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    WAIT_R: begin
                        if (cnv_cmplt) begin
                            accum <= 17'(acc_ext + a2d_sh);
                            timer <= '0;
                            state <= GAP;
                        end else if (timer == CNV_LAST) begin
                            fault <= 1'b1;
                            accum <= '0;
                            k     <= '0;
                            timer <= '0;
                            state <= SETTLE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    GAP: begin
                        if (timer == GAP_LAST) begin
                            start_conv <= 1'b1;
                            chnnl      <= ch_l;
                            timer      <= '0;
                            state      <= WAIT_L;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    WAIT_L: begin
                        if (cnv_cmplt) begin
                            accum <= 17'(acc_ext - a2d_sh);
                            timer <= '0;
                            if (k == LAST_K) begin
                                state <= ERR;
                            end else begin
                                k     <= k + 2'd1;
                                state <= SETTLE;
                            end
                        end else if (timer == CNV_LAST) begin
                            fault <= 1'b1;
                            accum <= '0;
                            k     <= '0;
                            timer <= '0;
                            state <= SETTLE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    ERR: begin
                        error <= sat12(acc_ext);
                        accum <= '0;
                        state <= INTG;
                    end
                    INTG: begin
                        if (int_cnt == INT_LAST) begin
                            intgrl  <= sat12(intg_sum);
                            int_cnt <= '0;
                        end else begin
                            int_cnt <= int_cnt + IW'(1);
                        end
                        fwd   <= fwd_nxt;
                        state <= COMP;
                    end
                    COMP: begin
                        pcomp <= sat12(p_prod);
                        icomp <= sat12(i_prod);
                        state <= OUT;
                    end
                    OUT: begin
                        rht_reg <= sat12(rht_sum);
                        lft_reg <= sat12(lft_sum);
                        update  <= 1'b1;
                        k       <= '0;
                        timer   <= '0;
                        state   <= SETTLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_follow_pi_ctrl.sv
// Scoreboard bench for line_follow_pi_ctrl: an A2D responder feeds conversions into an
// arithmetic reference model; a monitor compares every update against the queued result.
module tb_line_follow_pi_ctrl;

    localparam int NP     = 3;
    localparam int SETTLE = 300;
    localparam int GAPC   = 6;
    localparam int TMO    = 40;
    localparam int FWDMAX = 16;
    localparam int PGAIN  = 13952;
    localparam int IGAIN  = 1280;
    localparam int INTDEC = 4;
    localparam int DUTY   = 140;

    logic          clk = 1'b0;
    logic          rst_n, go, cnv_cmplt;
    logic [11:0]   A2D_res;
    logic          start_conv, update, fault;
    logic [2:0]    chnnl;
    logic [NP-1:0] IR_en;
    logic [7:0]    LEDs;
    logic [10:0]   lft, rht;

    line_follow_pi_ctrl #(
        .NUM_PAIRS  (NP),
        .SETTLE_CLKS(SETTLE),
        .GAP_CLKS   (GAPC),
        .CNV_TIMEOUT(TMO),
        .FWD_MAX    (12'(FWDMAX))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res),
        .start_conv(start_conv),
        .chnnl     (chnnl),
        .IR_en     (IR_en),
        .LEDs      (LEDs),
        .lft       (lft),
        .rht       (rht),
        .update    (update),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model
    typedef struct { int l; int r; int leds; } exp_t;
    exp_t expq[$];
    int m_n, m_intg, m_fwd, last_l, last_r;
    int rv[4], lv[4];

    function automatic int sat12(input int v);
        return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    endfunction

    function automatic int fdiv(input int v, input int d);
        return (v >= 0) ? v / d : -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_n = 0; m_intg = 0; m_fwd = 0; last_l = 0; last_r = 0;
        expq.delete();
    endtask

    task automatic model_cycle();
        int acc, err, p, i, r, l;
        exp_t e;
        acc = 0;
        for (int q = 0; q < NP; q++) acc += (rv[q] - lv[q]) * (1 << q);
        err = sat12(acc);
        m_n++;
        if (m_n % INTDEC == 0) m_intg = sat12(m_intg + fdiv(err, 16));
        m_fwd = (m_fwd + 1 > FWDMAX) ? FWDMAX : m_fwd + 1;
        p = sat12(fdiv(err * PGAIN, 4096));
        i = sat12(fdiv(m_intg * IGAIN, 4096));
        r = sat12(m_fwd - p - i);
        l = sat12(m_fwd + p + i);
        e.l = fdiv(l, 2);
        e.r = fdiv(r, 2);
        e.leds = ((err + 4096) % 4096) / 16;
        expq.push_back(e);
    endtask

    // A2D responder
    int exp_chan[6] = '{1, 0, 4, 2, 3, 7};
    int chan_val[8];
    int mode = 0;
    int slot = 0;
    int withhold_slot = -1;
    bit withheld = 0;
    int withheld_cyc = 0;
    int last_cmplt_cyc = 0;

    initial begin
        cnv_cmplt = 1'b0;
        A2D_res   = '0;
        forever begin
            int s_cyc, ch, kk, lat, v;
            @(negedge clk);
            if (start_conv === 1'b1) begin
                s_cyc = cyc;
                ch    = int'(chnnl);
                kk    = slot / 2;
                check("chnnl_order", ch, exp_chan[slot]);
                if (slot % 2 == 1)
                    check("gap_clks", s_cyc - last_cmplt_cyc - 1, GAPC);
                else if (slot != 0)
                    check("settle_clks", s_cyc - last_cmplt_cyc - 1, SETTLE);
                if (slot == withhold_slot) begin
                    withhold_slot = -1;
                    withheld_cyc  = s_cyc;
                    withheld      = 1;
                    slot          = 0;
                end else begin
                    lat = $urandom_range(1, 4);
                    v   = (mode != 0) ? $urandom_range(0, 4095) : chan_val[ch];
                    for (int j = 0; j < lat; j++) begin
                        @(negedge clk);
                        if (j == 0) check("start_conv_width", int'(start_conv), 0);
                    end
                    cnv_cmplt      = 1'b1;
                    A2D_res        = 12'(v);
                    last_cmplt_cyc = cyc;
                    if (slot % 2 == 0) rv[kk] = v; else lv[kk] = v;
                    @(negedge clk);
                    cnv_cmplt = 1'b0;
                    A2D_res   = 12'($urandom_range(0, 4095));
                    if (slot == 2 * NP - 1) begin
                        slot = 0;
                        model_cycle();
                    end else begin
                        slot++;
                    end
                end
            end
        end
    end

    // Monitor
    int n_upd = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (update === 1'b1) begin
                n_upd++;
                if (expq.size() == 0) begin
                    flag_fail("unexpected_update");
                end else begin
                    e = expq.pop_front();
                    check("lft", int'($signed(lft)), e.l);
                    check("rht", int'($signed(rht)), e.r);
                    check("LEDs", int'(LEDs), e.leds);
                    last_l = e.l;
                    last_r = e.r;
                end
            end
        end
    end

    task automatic wait_updates(input int target);
        int b;
        b = 0;
        while (n_upd < target && b < 20000) begin
            @(negedge clk);
            b++;
        end
        if (n_upd < target) flag_fail("update_timeout");
    endtask

    task automatic wait_withheld();
        int b;
        b = 0;
        while (!withheld && b < 4 * SETTLE) begin
            @(negedge clk);
            b++;
        end
        if (!withheld) flag_fail("withhold_timeout");
        withheld = 0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_lft"}, int'(lft), 0);
        check({tag, "_rht"}, int'(rht), 0);
        check({tag, "_LEDs"}, int'(LEDs), 0);
        check({tag, "_IR_en"}, int'(IR_en), 0);
        check({tag, "_start_conv"}, int'(start_conv), 0);
        check({tag, "_update"}, int'(update), 0);
        check({tag, "_fault"}, int'(fault), 0);
    endtask

    initial begin
        int cnt, b;
        rst_n = 1'b0;
        go    = 1'b0;
        model_reset();
        for (int c = 0; c < 8; c++) chan_val[c] = 12'h400;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        check("reset_chnnl", int'(chnnl), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Balanced sensors; PWM counter is still in its high phase shortly after reset
        go = 1'b1;
        @(negedge clk);
        check("ir_en_first", int'(IR_en), 1);
        cnt = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            cnt += int'(IR_en[0]);
            if (IR_en[NP-1:1] != '0) flag_fail("ir_en_other_pair");
        end
        check("ir_pwm_duty", cnt, DUTY);
        wait_updates(4);

        // Right-heavy pair 2
        for (int c = 0; c < 8; c++) chan_val[c] = 0;
        chan_val[3] = 12'hFFF;
        wait_updates(n_upd + 3);
        check("heavy_rht_lt_lft", int'(int'($signed(rht)) < int'($signed(lft))), 1);

        // Random
        mode = 1;
        wait_updates(n_upd + 8);

        // Conversion timeout in WAIT_R
        withhold_slot = 0;
        wait_withheld();
        b = 0;
        while (fault !== 1'b1 && b < TMO + 20) begin
            @(negedge clk);
            b++;
        end
        check("timeout_fault", int'(fault), 1);
        check("timeout_clks", cyc - withheld_cyc, TMO);
        check("timeout_lft_hold", int'($signed(lft)), last_l);
        check("timeout_rht_hold", int'($signed(rht)), last_r);
        wait_updates(n_upd + 2);
        check("fault_sticky", int'(fault), 1);

        // Abort with go low
        wait_updates(n_upd + 1);
        go = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        model_reset();
        slot = 0;
        go = 1'b1;
        wait_updates(n_upd + 2);

        // Asynchronous reset while waiting for a left conversion
        withhold_slot = 1;
        wait_withheld();
        #2 rst_n = 1'b0;
        #1 check_cleared("async_reset");
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        slot = 0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        check("ir_en_after_reset", int'(IR_en), 1);
        wait_updates(n_upd + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
